// File: rtl/div_operand_queue.sv
// Operand-pair FIFO that sequences a multi-cycle divider: launch head, wait for valid, capture, clear.
// Build option DIVQ_DVZ_BYPASS_EN: b==0 heads are answered locally without a divider run.
module div_operand_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [9:0]             in_a,
  input  logic [9:0]             in_b,
  output logic [9:0]             div_a,
  output logic [9:0]             div_b,
  output logic                   div_start,
  output logic                   div_sclr,
  input  logic                   div_busy,
  input  logic                   div_valid,
  input  logic [9:0]             div_q,
  input  logic                   div_dvz,
  input  logic                   div_ovf,
  output logic [9:0]             res_q,
  output logic                   res_dvz,
  output logic                   res_ovf,
  output logic                   res_valid,
  output logic [$clog2(DEPTH):0] pending,
  output logic [2:0]             o_dbg_state
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [9:0]    r_mem_a [DEPTH];
  logic [9:0]    r_mem_b [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          r_bypass;
  logic [9:0]    r_res_q;
  logic          r_res_dvz;
  logic          r_res_ovf;
  logic          w_push;
  logic          w_pop;
  logic          w_bypass_go;
  logic          w_unused_busy;

  // in_valid/in_ready: a pair transfers on every clk edge where both are high; in_valid
  // never depends on in_ready, and a full queue does not accept even while popping.
  assign in_ready = (r_state != S_INIT) && (r_count != FULL);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_state == S_CLEAR);

  // Sequencing relies on div_valid alone; busy is status only.
  assign w_unused_busy = div_busy;

`ifdef DIVQ_DVZ_BYPASS_EN
  assign w_bypass_go = (r_state == S_IDLE) && (r_count != '0) && (r_mem_b[r_head] == 10'd0);
`else
  assign w_bypass_go = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_a[i] <= '0;
        r_mem_b[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem_a[r_tail] <= in_a;
        r_mem_b[r_tail] <= in_b;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:   w_next = S_IDLE;
      S_IDLE: begin
        if (w_bypass_go) begin
          w_next = S_CLEAR;
        end else if (r_count != '0) begin
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        if (div_valid) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR:  w_next = S_IDLE;
      default:  w_next = S_INIT;
    endcase
  end

  always_comb begin
    div_start = 1'b0;
    div_sclr  = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      // INIT is also the reset state; the clear must only appear once reset is released.
      S_INIT:   div_sclr = rst_n;
      S_LAUNCH: div_start = 1'b1;
      S_CLEAR: begin
        div_sclr  = ~r_bypass;
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bypass  <= 1'b0;
      r_res_q   <= '0;
      r_res_dvz <= 1'b0;
      r_res_ovf <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_bypass <= w_bypass_go;
      end
      if ((r_state == S_WAIT) && div_valid) begin
        r_res_q   <= div_q;
        r_res_dvz <= div_dvz;
        r_res_ovf <= div_ovf;
      end else if (w_bypass_go) begin
        r_res_q   <= 10'h3FF;
        r_res_dvz <= 1'b1;
        r_res_ovf <= 1'b0;
      end
    end
  end

  // Head stays put until the CLEAR pop, so the operands are stable for the whole run.
  assign div_a       = r_mem_a[r_head];
  assign div_b       = r_mem_b[r_head];
  assign res_q       = r_res_q;
  assign res_dvz     = r_res_dvz;
  assign res_ovf     = r_res_ovf;
  assign pending     = r_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div_operand_queue.sv
// Bench for div_operand_queue: 12-cycle divider stub, queue-based reference model, directed + random steps.
// Build with +define+DIVQ_DVZ_BYPASS_EN to exercise the local divide-by-zero path.
module tb_div_operand_queue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_a;
  logic [9:0] in_b;
  logic [9:0] div_a;
  logic [9:0] div_b;
  logic       div_start;
  logic       div_sclr;
  logic       div_busy;
  logic       div_valid;
  logic [9:0] div_q;
  logic       div_dvz;
  logic       div_ovf;
  logic [9:0] res_q;
  logic       res_dvz;
  logic       res_ovf;
  logic       res_valid;
  logic [2:0] pending;
  logic [2:0] dbg_state;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  logic       chk_en = 1'b0;
  logic       stub_fix_en = 1'b0;
  logic [9:0] stub_fix_q = '0;
  logic       stub_spur = 1'b0;

  div_operand_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .div_a(div_a), .div_b(div_b),
    .div_start(div_start), .div_sclr(div_sclr), .div_busy(div_busy),
    .div_valid(div_valid), .div_q(div_q), .div_dvz(div_dvz), .div_ovf(div_ovf),
    .res_q(res_q), .res_dvz(res_dvz), .res_ovf(res_ovf), .res_valid(res_valid),
    .pending(pending), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- divider stub ----------------
  // Result rule of the stub: {q, dvz, ovf}. Division by zero returns q=a with dvz set.
  function automatic logic [11:0] stub_rule(input logic [9:0] a, input logic [9:0] b,
                                            input logic fix_en, input logic [9:0] fix_q);
    logic [9:0] q;
    if (b == 10'd0) return {a, 1'b1, 1'b0};
    q = a / b;
    return {(fix_en ? fix_q : q), 1'b0, (q > 10'h0FF)};
  endfunction

  logic        st_valid = 1'b0;
  logic        st_busy = 1'b0;
  logic [3:0]  st_cnt = '0;
  logic [9:0]  st_a = '0;
  logic [9:0]  st_b = '0;
  logic [11:0] st_out;

  always @(posedge clk) begin
    if (div_sclr) begin
      st_valid <= 1'b0;
      st_busy  <= 1'b0;
      st_cnt   <= '0;
    end else if (div_start) begin
      st_busy <= 1'b1;
      st_cnt  <= 4'd12;
      st_a    <= div_a;
      st_b    <= div_b;
    end else if (st_busy) begin
      if (st_cnt == 4'd1) begin
        st_busy  <= 1'b0;
        st_valid <= 1'b1;
      end
      st_cnt <= st_cnt - 4'd1;
    end
  end

  assign st_out    = stub_rule(st_a, st_b, stub_fix_en, stub_fix_q);
  assign div_q     = st_out[11:2];
  assign div_dvz   = st_out[1];
  assign div_ovf   = st_out[0];
  assign div_busy  = st_busy;
  assign div_valid = st_valid | stub_spur;

  // ---------------- reference model ----------------
  logic [19:0] exp_q[$];   // queued {a,b}, head = entry in flight

  function automatic logic [11:0] ref_result(input logic [19:0] e);
`ifdef DIVQ_DVZ_BYPASS_EN
    if (e[9:0] == 10'd0) return {10'h3FF, 1'b1, 1'b0};
`endif
    return stub_rule(e[19:10], e[9:0], stub_fix_en, stub_fix_q);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transfers and pops take effect on the rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (res_valid && (exp_q.size() != 0)) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back({in_a, in_b});
    end
  end

  // ---------------- scoreboard ----------------
  int          cyc = 0;
  int          last_start = -100;
  logic [11:0] last_res = '0;

  always @(negedge clk) begin
    logic [11:0] e;
    logic        exp_sclr;
    cyc++;
    if (!rst_n) begin
      last_res   = '0;
      last_start = -100;
    end else if (chk_en) begin
      check("pending", 32'(pending), 32'(exp_q.size()));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
      if (div_start) begin
        check("start_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("start_a", 32'(div_a), 32'(exp_q[0][19:10]));
          check("start_b", 32'(div_b), 32'(exp_q[0][9:0]));
`ifdef DIVQ_DVZ_BYPASS_EN
          check("start_b_nonzero", 32'(div_b != 10'd0), 32'd1);
`endif
        end
        check("start_spacing", 32'((cyc - last_start) >= 4), 32'd1);
        last_start = cyc;
      end
      if (res_valid) begin
        check("res_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = ref_result(exp_q[0]);
          exp_sclr = 1'b1;
`ifdef DIVQ_DVZ_BYPASS_EN
          if (exp_q[0][9:0] == 10'd0) exp_sclr = 1'b0;
`endif
          check("res_q", 32'(res_q), 32'(e[11:2]));
          check("res_dvz", 32'(res_dvz), 32'(e[1]));
          check("res_ovf", 32'(res_ovf), 32'(e[0]));
          check("clear_sclr", 32'(div_sclr), 32'(exp_sclr));
          check("clear_ops", 32'({div_a, div_b}), 32'(exp_q[0]));
          last_res = e;
        end
      end else begin
        check("res_hold", 32'({res_q, res_dvz, res_ovf}), 32'(last_res));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [9:0] a, input logic [9:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", 32'(in_ready), 32'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return div_start;
      1:       return res_valid;
      default: return div_valid;
    endcase
  endfunction

  // Ends on the falling edge where the selected signal is first seen high.
  task automatic wait_sig(input int s, input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(s) && n < budget);
    check(tag, 32'(sig(s)), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((pending != 3'd0 || res_valid) && n < budget);
    check("drain", 32'(pending), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({in_ready, div_start, div_sclr, res_valid, pending, res_dvz, res_ovf}), 32'd0);
    check({tag, "_ops"}, 32'({div_a, div_b}), 32'd0);
    check({tag, "_resq"}, 32'(res_q), 32'd0);
  endtask

  function automatic logic [9:0] rand_b();
    int unsigned r = $urandom_range(0, 7);
    if (r == 0) return 10'd0;
    if (r == 1) return 10'($urandom_range(1, 3));
    return 10'($urandom_range(1, 1023));
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int sclr_cnt;
    logic [2:0] st0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("init_sclr", 32'(div_sclr), 32'd1);
    check("init_in_ready", 32'(in_ready), 32'd0);
    check("init_pending", 32'(pending), 32'd0);
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("idle_sclr", 32'(div_sclr), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // single operation, fixed stub quotient
    stub_fix_en = 1'b1;
    stub_fix_q  = 10'h112;
    push(10'h2D0, 10'h0A8);
    @(negedge clk);
    check("r36_no_start_yet", 32'(div_start), 32'd0);
    check("r36_pending1", 32'(pending), 32'd1);
    @(negedge clk);
    check("r36_start", 32'(div_start), 32'd1);
    check("r36_div_a", 32'(div_a), 32'h2D0);
    wait_sig(2, 20, "r36_stub_valid");
    check("r36_no_res_yet", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("r36_res_valid", 32'(res_valid), 32'd1);
    check("r36_res_q", 32'(res_q), 32'h112);
    @(negedge clk);
    check("r36_pending0", 32'(pending), 32'd0);
    check("r36_res_hold", 32'(res_q), 32'h112);
    #1 stub_fix_en = 1'b0;
    @(posedge clk);
    #1;

    // fill the queue; the fifth pair waits until the first pop
    for (int i = 0; i < 4; i++) push(10'($urandom_range(0, 1023)), 10'($urandom_range(1, 1023)));
    @(negedge clk);
    check("r37_full_ready", 32'(in_ready), 32'd0);
    check("r37_full_pending", 32'(pending), 32'd4);
    #1;
    in_a = 10'($urandom_range(0, 1023));
    in_b = 10'($urandom_range(1, 1023));
    in_valid = 1'b1;
    wait_sig(1, 40, "r37_first_clear");
    check("r37_clear_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("r37_after_clear_ready", 32'(in_ready), 32'd1);
    check("r37_after_clear_pending", 32'(pending), 32'd3);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("r37_fifth_in", 32'(pending), 32'd4);
    wait_drain(200);

    // divide by zero
    push(10'h010, 10'h000);
`ifdef DIVQ_DVZ_BYPASS_EN
    @(negedge clk);
    check("r38_no_start_a", 32'(div_start), 32'd0);
    @(negedge clk);
    check("r38_no_start_b", 32'(div_start), 32'd0);
    check("r38_res_valid", 32'(res_valid), 32'd1);
    check("r38_res", 32'({res_q, res_dvz, res_ovf}), 32'({10'h3FF, 1'b1, 1'b0}));
    check("r38_no_sclr", 32'(div_sclr), 32'd0);
`else
    @(negedge clk);
    @(negedge clk);
    check("r38_start", 32'(div_start), 32'd1);
    wait_sig(1, 30, "r38_res_seen");
    check("r38_res_dvz", 32'(res_dvz), 32'd1);
    check("r38_res_q", 32'(res_q), 32'h010);
`endif
    wait_drain(60);

    // push on the pop edge with two queued
    push(10'h1C0, 10'h040);
    push(10'h250, 10'h088);
    wait_sig(1, 40, "r41_clear");
    check("r41_pending_before", 32'(pending), 32'd2);
    check("r41_ready", 32'(in_ready), 32'd1);
    #1;
    in_a = 10'($urandom_range(0, 1023));
    in_b = 10'($urandom_range(1, 1023));
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("r41_pending_after", 32'(pending), 32'd2);
    wait_sig(0, 10, "r41_next_start");
    check("r41_next_a", 32'(div_a), 32'h250);
    check("r41_next_b", 32'(div_b), 32'h088);
    wait_drain(200);

    // stray div_valid while idle
    @(negedge clk);
    st0 = dbg_state;
    #1 stub_spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("r40_no_res", 32'(res_valid), 32'd0);
      check("r40_no_start", 32'(div_start), 32'd0);
      check("r40_state", 32'(dbg_state), 32'(st0));
    end
    #1 stub_spur = 1'b0;
    @(posedge clk);
    #1;

    // reset while the divider is running
    push(10'($urandom_range(0, 1023)), 10'($urandom_range(1, 1023)));
    wait_sig(0, 10, "r39_start");
    repeat (4) @(negedge clk);
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1 check_all_zero("r39_reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("r39_init_sclr", 32'(div_sclr), 32'd1);
    check("r39_pending", 32'(pending), 32'd0);
    check("r39_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 chk_en = 1'b1;
    sclr_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (div_sclr) sclr_cnt++;
    end
    check("r39_single_sclr", 32'(sclr_cnt), 32'd0);
    @(posedge clk);
    #1;

    // random traffic
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      push(10'($urandom_range(0, 1023)), rand_b());
    end
    wait_drain(600);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
